// File: rtl/long_mul_div_unit_if.sv
// Request/response bundle between the execute pipeline and the multiply/divide unit.
interface long_mul_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_oper;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_hi;
    logic [WIDTH-1:0] out_lo;
    logic             out_dz;

    // Pipeline side: issues requests and consumes results.
    modport master (
        output flush, in_valid, in_oper, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_hi, out_lo, out_dz
    );

    // Unit side.
    modport slave (
        input  flush, in_valid, in_oper, in_a, in_b, out_ready,
        output in_ready, out_valid, out_hi, out_lo, out_dz
    );
endinterface

// File: rtl/long_mul_div_unit.sv
// Iterative radix-2 multiply/divide unit: signed/unsigned double-width product or
// quotient/remainder, fixed latency of WIDTH+1 edges from accept to result valid.
module long_mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic                 clk,
    input logic                 rst,
    long_mul_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           oper_q;
    logic [WIDTH-1:0]     opa_q;      // |a|: multiplicand, or dividend shifting out MSB first
    logic [WIDTH-1:0]     opb_q;      // |b|: multiplier shifting out LSB first, or divisor
    logic [2*WIDTH-1:0]   acc_q;      // product, or {remainder, quotient}
    logic [WIDTH-1:0]     a_orig_q;   // raw dividend, returned on divide by zero
    logic                 neg_lo_q;   // negate product / quotient
    logic                 neg_hi_q;   // negate remainder
    logic                 dz_q;
    logic [WIDTH-1:0]     out_hi_q, out_lo_q;
    logic                 out_dz_q;

    logic                 a_neg, b_neg;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_borrow;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem;
    logic [WIDTH-1:0]     res_hi, res_lo;
    logic                 res_dz;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.in_valid) state_d = StRun;
                StRun:   if (cnt_q == CNT_W'(1)) state_d = StFix;
                StFix:   state_d = StDone;
                StDone:  if (bus.out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.out_hi    = out_hi_q;
        bus.out_lo    = out_lo_q;
        bus.out_dz    = out_dz_q;
    end

    // One radix-2 step of shift-add multiply and restoring divide.
    always_comb begin
        a_neg      = bus.in_oper[0] & bus.in_a[WIDTH-1];
        b_neg      = bus.in_oper[0] & bus.in_b[WIDTH-1];
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (opb_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        div_shift  = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
        // Partial remainder is below 2*divisor, so MSB of the W+1 bit difference is the borrow.
        div_diff   = div_shift - {1'b0, opb_q};
        div_borrow = div_diff[WIDTH];
        div_rem    = div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    end

    // Sign fix-up and special-case selection of the final result.
    always_comb begin
        prod   = neg_lo_q ? -acc_q : acc_q;
        quot   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem    = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        res_dz = 1'b0;
        if (oper_q[1]) begin
            if (dz_q) begin
                res_lo = '1;
                res_hi = a_orig_q;
                res_dz = 1'b1;
            end else begin
                res_lo = quot;
                res_hi = rem;
            end
        end
    end

    // Operand capture, iteration datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            out_hi_q <= '0;
            out_lo_q <= '0;
            out_dz_q <= 1'b0;
        end else begin
            if (state_q == StIdle && state_d == StRun) begin
                oper_q   <= bus.in_oper;
                opa_q    <= a_neg ? -bus.in_a : bus.in_a;
                opb_q    <= b_neg ? -bus.in_b : bus.in_b;
                a_orig_q <= bus.in_a;
                neg_lo_q <= a_neg ^ b_neg;
                neg_hi_q <= a_neg;
                dz_q     <= (bus.in_b == '0);
                acc_q    <= '0;
                cnt_q    <= CNT_W'(WIDTH);
            end else if (state_q == StRun) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (oper_q[1]) begin
                    acc_q <= {div_rem, acc_q[WIDTH-2:0], ~div_borrow};
                    opa_q <= {opa_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    opb_q <= {1'b0, opb_q[WIDTH-1:1]};
                end
            end
            if (state_q == StFix && !bus.flush) begin
                out_hi_q <= res_hi;
                out_lo_q <= res_lo;
                out_dz_q <= res_dz;
            end
        end
    end

endmodule
